// File: rtl/onp_conv_p.sv
// onp_conv_p: streaming infix-to-RPN converter (shunting-yard).
// Takes one ASCII char per input handshake and produces the RPN char stream on the
// output handshake. Precedence: '*' '/' above '+' '-'; all operators left-associative.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-low
//   in_stb     in_char valid
//   in_char    ASCII input char
//   in_ack     ready; a char is accepted on an edge with in_stb & in_ack
//   out_stb    out_char valid (registered, held until out_ack)
//   out_char   ASCII output char
//   out_ack    output char taken on an edge with out_stb & out_ack
//   done       1-cycle pulse after '=' has been emitted (or '=' clears an error)
//   err        sticky: 00 none, 01 stack overflow, 10 bracket mismatch, 11 illegal char
//   stack_lvl  current operator/bracket stack occupancy
module onp_conv_p #(
   parameter int unsigned STACK_DEPTH = 16,
   parameter int unsigned EMIT_SEP    = 1,
   localparam int unsigned LW = $clog2(STACK_DEPTH + 1),
   localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_stb,
   input  logic [7:0]    in_char,
   output logic          in_ack,
   output logic          out_stb,
   output logic [7:0]    out_char,
   input  logic          out_ack,
   output logic          done,
   output logic [1:0]    err,
   output logic [LW-1:0] stack_lvl
);

   typedef enum logic [3:0] {
      StIdle, StDecode, StSep, StEmit, StPop, StPush, StFlush, StTerm, StError
   } state_e;

   localparam logic [1:0]    ErrOvf     = 2'b01;
   localparam logic [1:0]    ErrBracket = 2'b10;
   localparam logic [1:0]    ErrChar    = 2'b11;
   localparam logic [LW-1:0] Full       = LW'(STACK_DEPTH);

   state_e          state_q, state_d, ret_q, ret_d;
   logic [7:0]      chr_q, chr_d, tok_q, tok_d;
   logic            out_stb_q, out_stb_d, done_q, done_d;
   logic [7:0]      out_char_q, out_char_d;
   logic [1:0]      err_q, err_d;
   logic [LW-1:0]   lvl_q, lvl_d;
   logic [7:0]      stk_q [STACK_DEPTH];
   logic [7:0]      stk_d [STACK_DEPTH];
   logic            num_q, num_d, emitted_q, emitted_d;

   logic            emit_req, emit_cont, err_req, do_push;
   logic [7:0]      emit_tok, top_c, nxt_c;
   state_e          emit_ret;
   logic [1:0]      err_code;
   logic [IW-1:0]   top_idx;

   function automatic logic [1:0] prec(input logic [7:0] c);
      case (c)
         "*", "/": prec = 2'd2;
         "+", "-": prec = 2'd1;
         default:  prec = 2'd0;
      endcase
   endfunction

   // Top t must be an operator binding at least as tightly as incoming op c.
   function automatic logic pop_ok(input logic [7:0] t, input logic [7:0] c);
      pop_ok = (prec(t) != 2'd0) && (prec(t) >= prec(c));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      is_digit = (c >= "0") && (c <= "9");
   endfunction

   assign top_idx = IW'(lvl_q - LW'(1));
   assign top_c   = (lvl_q != '0) ? stk_q[top_idx] : 8'h00;
   assign nxt_c   = (lvl_q >= LW'(2)) ? stk_q[IW'(lvl_q - LW'(2))] : 8'h00;

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      chr_d      = chr_q;
      tok_d      = tok_q;
      out_stb_d  = out_stb_q;
      out_char_d = out_char_q;
      done_d     = 1'b0;
      err_d      = err_q;
      lvl_d      = lvl_q;
      stk_d      = stk_q;
      num_d      = num_q;
      emitted_d  = emitted_q;
      emit_req   = 1'b0;
      emit_tok   = 8'h00;
      emit_cont  = 1'b0;
      emit_ret   = StIdle;
      err_req    = 1'b0;
      err_code   = 2'b00;
      do_push    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_stb) begin
               chr_d   = in_char;
               state_d = StDecode;
            end
         end
         StDecode: begin
            num_d = 1'b0;
            if (is_digit(chr_q)) begin
               num_d     = 1'b1;
               emit_req  = 1'b1;
               emit_tok  = chr_q;
               emit_cont = num_q;
            end else if (chr_q == " ") begin
               state_d = StIdle;
            end else if (chr_q == "(") begin
               do_push = 1'b1;
            end else if (chr_q == ")") begin
               if (lvl_q == '0) begin
                  err_req  = 1'b1;
                  err_code = ErrBracket;
               end else if (top_c == "(") begin
                  lvl_d   = lvl_q - LW'(1);
                  state_d = StIdle;
               end else begin
                  state_d = StPop;
               end
            end else if (chr_q == "=") begin
               state_d = StFlush;
            end else if (prec(chr_q) != 2'd0) begin
               if (pop_ok(top_c, chr_q)) state_d = StPop;
               else                      do_push = 1'b1;
            end else begin
               err_req  = 1'b1;
               err_code = ErrChar;
            end
         end
         // Looks one entry below the top so the last pop already knows it is the last,
         // letting in_ack return right after that char's final output transfer.
         StPop: begin
            if (chr_q == ")") begin
               if (lvl_q == '0) begin
                  err_req  = 1'b1;
                  err_code = ErrBracket;
               end else if (top_c == "(") begin
                  lvl_d   = lvl_q - LW'(1);
                  state_d = StIdle;
               end else begin
                  emit_req = 1'b1;
                  emit_tok = top_c;
                  if (nxt_c == "(") begin
                     lvl_d = lvl_q - LW'(2);
                  end else begin
                     lvl_d    = lvl_q - LW'(1);
                     emit_ret = StPop;
                  end
               end
            end else if (pop_ok(top_c, chr_q)) begin
               emit_req = 1'b1;
               emit_tok = top_c;
               if (pop_ok(nxt_c, chr_q)) begin
                  lvl_d    = lvl_q - LW'(1);
                  emit_ret = StPop;
               end else begin
                  // Pop and push in one go: the new op takes the popped slot.
                  stk_d[top_idx] = chr_q;
               end
            end else begin
               state_d = StPush;
            end
         end
         StPush: do_push = 1'b1;
         StFlush: begin
            if (lvl_q == '0) begin
               state_d = StTerm;
            end else if (top_c == "(") begin
               err_req  = 1'b1;
               err_code = ErrBracket;
            end else begin
               emit_req = 1'b1;
               emit_tok = top_c;
               lvl_d    = lvl_q - LW'(1);
               emit_ret = (lvl_q == LW'(1)) ? StTerm : StFlush;
            end
         end
         StTerm: begin
            out_stb_d  = 1'b1;
            out_char_d = "=";
            state_d    = StEmit;
         end
         StSep: begin
            if (out_ack) begin
               out_char_d = tok_q;
               state_d    = StEmit;
            end
         end
         StEmit: begin
            if (out_ack) begin
               out_stb_d = 1'b0;
               // '=' is the only terminator ever emitted
               if (out_char_q == "=") begin
                  done_d    = 1'b1;
                  num_d     = 1'b0;
                  emitted_d = 1'b0;
                  state_d   = StIdle;
               end else begin
                  state_d = ret_q;
               end
            end
         end
         StError: begin
            if (in_stb && (in_char == "=")) begin
               err_d   = 2'b00;
               done_d  = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (do_push) begin
         if (lvl_q == Full) begin
            err_req  = 1'b1;
            err_code = ErrOvf;
         end else begin
            stk_d[IW'(lvl_q)] = chr_q;
            lvl_d             = lvl_q + LW'(1);
            state_d           = StIdle;
         end
      end

      if (emit_req) begin
         out_stb_d = 1'b1;
         emitted_d = 1'b1;
         ret_d     = emit_ret;
         if ((EMIT_SEP != 0) && emitted_q && !emit_cont) begin
            out_char_d = 8'h20;
            tok_d      = emit_tok;
            state_d    = StSep;
         end else begin
            out_char_d = emit_tok;
            state_d    = StEmit;
         end
      end

      if (err_req) begin
         if (err_q == 2'b00) err_d = err_code;
         lvl_d     = '0;
         num_d     = 1'b0;
         emitted_d = 1'b0;
         out_stb_d = 1'b0;
         state_d   = StError;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= StIdle;
         ret_q      <= StIdle;
         chr_q      <= 8'h00;
         tok_q      <= 8'h00;
         out_stb_q  <= 1'b0;
         out_char_q <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 2'b00;
         lvl_q      <= '0;
         num_q      <= 1'b0;
         emitted_q  <= 1'b0;
         for (int i = 0; i < int'(STACK_DEPTH); i++) stk_q[i] <= 8'h00;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         chr_q      <= chr_d;
         tok_q      <= tok_d;
         out_stb_q  <= out_stb_d;
         out_char_q <= out_char_d;
         done_q     <= done_d;
         err_q      <= err_d;
         lvl_q      <= lvl_d;
         num_q      <= num_d;
         emitted_q  <= emitted_d;
         stk_q      <= stk_d;
      end
   end

   assign in_ack    = (state_q == StIdle) || (state_q == StError);
   assign out_stb   = out_stb_q;
   assign out_char  = out_char_q;
   assign done      = done_q;
   assign err       = err_q;
   assign stack_lvl = lvl_q;

endmodule

// File: tb/tb_onp_conv_p.sv
// Directed bench for onp_conv_p: instance a uses defaults (depth 16, separators on),
// instance b uses depth 2 with separators off. sel routes stimulus to one of them.
module tb_onp_conv_p;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_stb, sel, out_ack;
   logic [7:0] in_char;

   logic       a_stb, a_in_ack, a_out_stb, a_done;
   logic [7:0] a_out_char;
   logic [1:0] a_err;
   logic [4:0] a_lvl;
   logic       b_stb, b_in_ack, b_out_stb, b_done;
   logic [7:0] b_out_char;
   logic [1:0] b_err;
   logic [1:0] b_lvl;

   logic       cur_in_ack, cur_out_stb, cur_done;
   logic [7:0] cur_out_char;
   logic [1:0] cur_err;
   logic [4:0] cur_lvl;

   int checks   = 0;
   int failures = 0;

   assign a_stb        = in_stb & ~sel;
   assign b_stb        = in_stb & sel;
   assign cur_in_ack   = sel ? b_in_ack : a_in_ack;
   assign cur_out_stb  = sel ? b_out_stb : a_out_stb;
   assign cur_out_char = sel ? b_out_char : a_out_char;
   assign cur_done     = sel ? b_done : a_done;
   assign cur_err      = sel ? b_err : a_err;
   assign cur_lvl      = sel ? {3'b000, b_lvl} : a_lvl;

   onp_conv_p u_a (
      .clk(clk), .rst(rst), .in_stb(a_stb), .in_char(in_char), .in_ack(a_in_ack),
      .out_stb(a_out_stb), .out_char(a_out_char), .out_ack(out_ack), .done(a_done),
      .err(a_err), .stack_lvl(a_lvl)
   );

   onp_conv_p #(.STACK_DEPTH(2), .EMIT_SEP(0)) u_b (
      .clk(clk), .rst(rst), .in_stb(b_stb), .in_char(in_char), .in_ack(b_in_ack),
      .out_stb(b_out_stb), .out_char(b_out_char), .out_ack(out_ack), .done(b_done),
      .err(b_err), .stack_lvl(b_lvl)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_s(input string tag, input string obs, input string exp);
      checks++;
      assert (obs == exp) else begin
         failures++;
         $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: record what the next rising edge transfers, then advance.
   task automatic tick(inout string got, inout int dn);
      if (cur_out_stb && out_ack) got = $sformatf("%s%c", got, cur_out_char);
      if (cur_done) dn++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic feed(input string s, inout string got, inout int dn);
      for (int i = 0; i < s.len(); i++) begin
         int n;
         n = 0;
         while (!cur_in_ack && n < 100) begin
            tick(got, dn);
            n++;
         end
         if (n == 100) chk("in_ack_wait", {31'd0, cur_in_ack}, 32'd1);
         in_char = s[i];
         in_stb  = 1'b1;
         tick(got, dn);
         in_stb  = 1'b0;
      end
      repeat (30) tick(got, dn);
   endtask

   task automatic run(input string tag, input string s, input string exp, input int exp_dn);
      string got;
      int    dn;
      got = "";
      dn  = 0;
      feed(s, got, dn);
      chk_s({tag, "_out"}, got, exp);
      chk({tag, "_done"}, dn, exp_dn);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      string got;
      int    dn;
      rst = 1'b0; in_stb = 1'b0; in_char = 8'h00; sel = 1'b0; out_ack = 1'b1;
      got = ""; dn = 0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ack", {31'd0, a_in_ack}, 32'd1);
      chk("rst_out_stb", {31'd0, a_out_stb}, 32'd0);
      chk("rst_out_char", {24'd0, a_out_char}, 32'd0);
      chk("rst_done", {31'd0, a_done}, 32'd0);
      chk("rst_err", {30'd0, a_err}, 32'd0);
      chk("rst_lvl", {27'd0, a_lvl}, 32'd0);
      chk("rst_b_in_ack", {31'd0, b_in_ack}, 32'd1);
      rst = 1'b1;
      @(negedge clk);

      // A space produces no output: ack low for one cycle, back the next
      in_char = " "; in_stb = 1'b1; tick(got, dn); in_stb = 1'b0;
      chk("space_ack_low", {31'd0, cur_in_ack}, 32'd0);
      tick(got, dn);
      chk("space_ack_back", {31'd0, cur_in_ack}, 32'd1);

      run("t1", "1+2=", "1 2 +=", 1);
      chk("t1_err", {30'd0, cur_err}, 32'd0);
      chk("t1_lvl", {27'd0, cur_lvl}, 32'd0);
      run("t2", "12+3*4=", "12 3 4 * +=", 1);
      run("t3a", "(1+2)*3=", "1 2 + 3 *=", 1);
      run("t3b", "8-4-2=", "8 4 - 2 -=", 1);
      run("t_div", "6/2*3=", "6 2 / 3 *=", 1);
      run("t_nest", "3*(4+5)=", "3 4 5 + *=", 1);
      run("t_eq", "=", "=", 1);

      // Bracket / illegal-char errors
      run("rpar", ")", "", 0);
      chk("rpar_err", {30'd0, cur_err}, 32'd2);
      chk("rpar_lvl", {27'd0, cur_lvl}, 32'd0);
      run("rpar_clr", "=", "", 1);
      chk("rpar_clr_err", {30'd0, cur_err}, 32'd0);
      run("ill", "1a", "1", 0);
      chk("ill_err", {30'd0, cur_err}, 32'd3);
      run("ill_clr", "2=", "", 1);
      chk("ill_clr_err", {30'd0, cur_err}, 32'd0);
      run("lpar", "(1=", "1", 0);
      chk("lpar_err", {30'd0, cur_err}, 32'd2);
      run("lpar_clr", "=", "", 1);

      // Output stall: held stable while out_ack is low
      out_ack = 1'b0;
      got = ""; dn = 0;
      in_char = "5"; in_stb = 1'b1; tick(got, dn); in_stb = 1'b0;
      tick(got, dn);
      for (int i = 0; i < 10; i++) begin
         chk("stall_out", {23'd0, cur_out_stb, cur_out_char}, {23'd0, 1'b1, 8'h35});
         chk("stall_ack", {31'd0, cur_in_ack}, 32'd0);
         tick(got, dn);
      end
      out_ack = 1'b1;
      feed("=", got, dn);
      chk_s("stall_res", got, "5=");
      chk("stall_done", dn, 1);

      // Reset mid-stream with a bracket on the stack and a char stuck on the output
      run("mid_pre", "(", "", 0);
      chk("mid_lvl1", {27'd0, cur_lvl}, 32'd1);
      out_ack = 1'b0;
      in_char = "1"; in_stb = 1'b1; tick(got, dn); in_stb = 1'b0;
      tick(got, dn);
      tick(got, dn);
      chk("mid_stuck", {31'd0, cur_out_stb}, 32'd1);
      rst = 1'b0;
      tick(got, dn);
      chk("mid_in_ack", {31'd0, a_in_ack}, 32'd1);
      chk("mid_out", {23'd0, a_out_stb, a_out_char}, 32'd0);
      chk("mid_err_lvl_done", {24'd0, a_err, a_lvl, a_done}, 32'd0);
      rst = 1'b1;
      out_ack = 1'b1;
      tick(got, dn);
      run("mid_post", "4=", "4=", 1);

      // Depth-2 instance, no separators
      sel = 1'b1;
      @(negedge clk);
      run("ovf_a", "((", "", 0);
      chk("ovf_lvl2", {27'd0, cur_lvl}, 32'd2);
      chk("ovf_err0", {30'd0, cur_err}, 32'd0);
      run("ovf_b", "(", "", 0);
      chk("ovf_err", {30'd0, cur_err}, 32'd1);
      chk("ovf_lvl0", {27'd0, cur_lvl}, 32'd0);
      run("ovf_c", "1=", "", 1);
      chk("ovf_clr", {30'd0, cur_err}, 32'd0);
      run("b_7", "7=", "7=", 1);
      run("b_nosep", "12+3=", "123+=", 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
